// File: rtl/regfile_writeback_queue.sv
// In-order write-back queue feeding the register file A3/WE3/WD3 port, with
// read-after-write forwarding for A1/A2 built only when WBQ_FORWARD_EN is defined.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [AW-1:0]              IN_ADDR,
    input  logic [DW-1:0]              IN_DATA,
    input  logic                       STALL,
    output logic                       WE3,
    output logic [AW-1:0]              A3,
    output logic [DW-1:0]              WD3,
    input  logic [AW-1:0]              A1,
    input  logic [AW-1:0]              A2,
    output logic                       FWD1_HIT,
    output logic                       FWD2_HIT,
    output logic [DW-1:0]              FWD1_DATA,
    output logic [DW-1:0]              FWD2_DATA,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       EMPTY
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign EMPTY    = (count == '0);
    assign COUNT    = count;
    assign IN_READY = RST_N & (count < CW'(DEPTH));

    // Writes to r0 are swallowed at the input: the handshake completes but nothing is stored.
    assign push = IN_VALID & IN_READY & (IN_ADDR != '0);
    assign pop  = WE3;

    assign WE3 = ~EMPTY & ~STALL;
    assign A3  = EMPTY ? '0 : addr_mem[rd_ptr];
    assign WD3 = EMPTY ? '0 : data_mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; entries are only observed while counted as live.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wr_ptr] <= IN_ADDR;
            data_mem[wr_ptr] <= IN_DATA;
        end
    end

`ifdef WBQ_FORWARD_EN
    logic [PW-1:0] slot;

    // Walk live entries oldest to youngest so the last match wins; the head still
    // counts as live in the cycle it retires.
    always_comb begin
        FWD1_HIT  = 1'b0;
        FWD1_DATA = '0;
        FWD2_HIT  = 1'b0;
        FWD2_DATA = '0;
        slot      = rd_ptr;
        for (int j = 0; j < DEPTH; j++) begin
            slot = rd_ptr + PW'(j);
            if (CW'(j) < count) begin
                if ((A1 != '0) && (addr_mem[slot] == A1)) begin
                    FWD1_HIT  = 1'b1;
                    FWD1_DATA = data_mem[slot];
                end
                if ((A2 != '0) && (addr_mem[slot] == A2)) begin
                    FWD2_HIT  = 1'b1;
                    FWD2_DATA = data_mem[slot];
                end
            end
        end
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^{A1, A2};
    assign FWD1_HIT  = 1'b0;
    assign FWD2_HIT  = 1'b0;
    assign FWD1_DATA = '0;
    assign FWD2_DATA = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef WBQ_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] IN_ADDR = '0;
    logic [DW-1:0] IN_DATA = '0;
    logic          STALL = 1'b0;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [AW-1:0] A1 = '0;
    logic [AW-1:0] A2 = '0;
    logic          FWD1_HIT;
    logic          FWD2_HIT;
    logic [DW-1:0] FWD1_DATA;
    logic [DW-1:0] FWD2_DATA;
    logic [CW-1:0] COUNT;
    logic          EMPTY;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] q_addr [$];
    logic [DW-1:0] q_data [$];

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA),
        .STALL(STALL), .WE3(WE3), .A3(A3), .WD3(WD3),
        .A1(A1), .A2(A2),
        .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
        .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA),
        .COUNT(COUNT), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Youngest pending write to a nonzero address, or no hit.
    function automatic logic [DW:0] exp_fwd(input logic [AW-1:0] ra);
        if (FWD_ON && ra != '0) begin
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
                if (q_addr[i] == ra) return {1'b1, q_data[i]};
            end
        end
        return '0;
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic s, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        @(negedge CLK);
        IN_VALID = v;
        IN_ADDR  = a;
        IN_DATA  = d;
        STALL    = s;
        A1       = r1;
        A2       = r2;
        #1;
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic commit();
        bit push_ok;
        bit pop_ok;
        push_ok = IN_VALID && (q_addr.size() < DEPTH) && (IN_ADDR != '0);
        pop_ok  = (q_addr.size() > 0) && !STALL;
        if (pop_ok) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
        end
        if (push_ok) begin
            q_addr.push_back(IN_ADDR);
            q_data.push_back(IN_DATA);
        end
    endtask

    task automatic test_reset();
        A1 = 5'd3;
        A2 = 5'd4;
        #2 RST_N = 1'b0;
        #2;
        n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", IN_READY); end
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL reset_we3: got %b want 0", WE3); end
        n_cmp++; if (A3 !== '0 || WD3 !== '0) begin n_err++; $display("FAIL reset_a3_wd3: got %h/%h want 0/0", A3, WD3); end
        n_cmp++; if (COUNT !== '0 || EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_count: got %0d/%b want 0/1", COUNT, EMPTY); end
        n_cmp++; if (FWD1_HIT !== 1'b0 || FWD2_HIT !== 1'b0 || FWD1_DATA !== '0 || FWD2_DATA !== '0) begin
            n_err++; $display("FAIL reset_fwd: got %b%b %h %h want zeros", FWD1_HIT, FWD2_HIT, FWD1_DATA, FWD2_DATA); end
        q_addr.delete();
        q_data.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", IN_READY); end
    endtask

    task automatic test_single();
        drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        n_cmp++; if (WE3 !== 1'b0) begin n_err++; $display("FAIL single_pre_we3: got %b want 0", WE3); end
        commit();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h11) begin
            n_err++; $display("FAIL single_write: got we=%b a=%0d d=%h want 1/3/11", WE3, A3, WD3); end
        commit();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++; if (EMPTY !== 1'b1 || WE3 !== 1'b0) begin n_err++; $display("FAIL single_after: got empty=%b we=%b want 1/0", EMPTY, WE3); end
        commit();
    endtask

    task automatic test_stall_fill();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b1, '0, '0);
            n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d: got %b want 1", i, IN_READY); end
            commit();
        end
        drive(1'b1, 5'd9, 32'h999, 1'b1, '0, '0);
        n_cmp++; if (COUNT !== CW'(4) || IN_READY !== 1'b0 || WE3 !== 1'b0) begin
            n_err++; $display("FAIL fill_full: got cnt=%0d rdy=%b we=%b want 4/0/0", COUNT, IN_READY, WE3); end
        commit();
        // Full and draining in the same cycle must still refuse the offered entry.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'd9, 32'h999, 1'b0, '0, '0);
            n_cmp++; if (WE3 !== 1'b1 || A3 !== AW'(i) || WD3 !== DW'(32'h100 + i)) begin
                n_err++; $display("FAIL drain_%0d: got we=%b a=%0d d=%h want 1/%0d/%h", i, WE3, A3, WD3, i, 32'h100 + i); end
            n_cmp++; if (IN_READY !== (q_addr.size() < DEPTH)) begin
                n_err++; $display("FAIL drain_ready_%0d: got %b want %b", i, IN_READY, q_addr.size() < DEPTH); end
            commit();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++; if (COUNT !== CW'(q_addr.size()) || A3 !== (q_addr.size() > 0 ? q_addr[0] : '0)) begin
            n_err++; $display("FAIL drain_tail: got cnt=%0d a=%0d want %0d", COUNT, A3, q_addr.size()); end
        commit();
        while (q_addr.size() > 0) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0);
            commit();
        end
    endtask

    task automatic test_forward();
        drive(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 5'd5);
        commit();
        drive(1'b1, 5'd5, 32'hB, 1'b1, 5'd5, 5'd5);
        commit();
        drive(1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
        n_cmp++; if (FWD1_HIT !== FWD_ON || FWD1_DATA !== (FWD_ON ? 32'hB : 32'h0)) begin
            n_err++; $display("FAIL fwd1_youngest: got %b/%h want %b/%h", FWD1_HIT, FWD1_DATA, FWD_ON, FWD_ON ? 32'hB : 32'h0); end
        n_cmp++; if (FWD2_HIT !== FWD_ON || FWD2_DATA !== (FWD_ON ? 32'hB : 32'h0)) begin
            n_err++; $display("FAIL fwd2_youngest: got %b/%h want %b", FWD2_HIT, FWD2_DATA, FWD_ON); end
        commit();
        drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd6);
        n_cmp++; if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hA) begin
            n_err++; $display("FAIL fwd_retire_a: got %b/%0d/%h want 1/5/a", WE3, A3, WD3); end
        n_cmp++; if (FWD2_HIT !== 1'b0) begin n_err++; $display("FAIL fwd2_miss: got %b want 0", FWD2_HIT); end
        commit();
        drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
        n_cmp++; if (FWD1_HIT !== FWD_ON || FWD1_DATA !== (FWD_ON ? 32'hB : 32'h0) || WD3 !== 32'hB) begin
            n_err++; $display("FAIL fwd_popping_entry: got %b/%h wd=%h want %b", FWD1_HIT, FWD1_DATA, WD3, FWD_ON); end
        commit();
        drive(1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
        n_cmp++; if (FWD1_HIT !== 1'b0 || FWD1_DATA !== '0) begin n_err++; $display("FAIL fwd_after_retire: got %b/%h want 0/0", FWD1_HIT, FWD1_DATA); end
        commit();
    endtask

    task automatic test_addr_zero();
        drive(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0);
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", IN_READY); end
        commit();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0);
            n_cmp++; if (COUNT !== '0 || WE3 !== 1'b0) begin n_err++; $display("FAIL zero_dropped_%0d: got cnt=%0d we=%b want 0/0", i, COUNT, WE3); end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd7, '0);
        commit();
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd7, '0);
        commit();
        drive(1'b0, '0, '0, 1'b0, 5'd7, '0);
        n_cmp++; if (COUNT !== CW'(2) || WE3 !== 1'b1) begin n_err++; $display("FAIL mid_pre: got cnt=%0d we=%b want 2/1", COUNT, WE3); end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++; if (WE3 !== 1'b0 || COUNT !== '0 || EMPTY !== 1'b1 || IN_READY !== 1'b0) begin
            n_err++; $display("FAIL mid_async: got we=%b cnt=%0d empty=%b rdy=%b want 0/0/1/0", WE3, COUNT, EMPTY, IN_READY); end
        n_cmp++; if (FWD1_HIT !== 1'b0 || A3 !== '0 || WD3 !== '0) begin
            n_err++; $display("FAIL mid_outputs: got hit=%b a=%0d d=%h want 0/0/0", FWD1_HIT, A3, WD3); end
        q_addr.delete();
        q_data.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b0, 5'd7, '0);
            n_cmp++; if (WE3 !== 1'b0 || COUNT !== '0) begin n_err++; $display("FAIL mid_stale_%0d: got we=%b cnt=%0d want 0/0", i, WE3, COUNT); end
            commit();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'((i % 7) + 1), DW'($urandom), 1'b0, '0, '0);
            n_cmp++; if (COUNT !== CW'(q_addr.size()) || COUNT > CW'(1)) begin
                n_err++; $display("FAIL b2b_count_%0d: got %0d want %0d", i, COUNT, q_addr.size()); end
            n_cmp++; if (WE3 !== (q_addr.size() > 0) || A3 !== (q_addr.size() > 0 ? q_addr[0] : '0)
                         || WD3 !== (q_data.size() > 0 ? q_data[0] : '0)) begin
                n_err++; $display("FAIL b2b_write_%0d: got %b/%0d/%h", i, WE3, A3, WD3); end
            commit();
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        n_cmp++; if (WE3 !== 1'b1 || A3 !== AW'((9 % 7) + 1)) begin n_err++; $display("FAIL b2b_last: got %b/%0d want 1/3", WE3, A3); end
        commit();
    endtask

    task automatic test_random();
        logic [DW:0] f1;
        logic [DW:0] f2;
        int          sz;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), DW'($urandom),
                  $urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            sz = q_addr.size();
            f1 = exp_fwd(A1);
            f2 = exp_fwd(A2);
            n_cmp++; if (COUNT !== CW'(sz) || EMPTY !== (sz == 0) || IN_READY !== (sz < DEPTH)) begin
                n_err++; $display("FAIL rnd_state_%0d: got cnt=%0d empty=%b rdy=%b want cnt=%0d", i, COUNT, EMPTY, IN_READY, sz); end
            n_cmp++; if (WE3 !== (sz > 0 && !STALL) || A3 !== (sz > 0 ? q_addr[0] : '0) || WD3 !== (sz > 0 ? q_data[0] : '0)) begin
                n_err++; $display("FAIL rnd_write_%0d: got %b/%0d/%h want %b/%0d/%h", i, WE3, A3, WD3,
                                  sz > 0 && !STALL, sz > 0 ? q_addr[0] : '0, sz > 0 ? q_data[0] : '0); end
            n_cmp++; if ({FWD1_HIT, FWD1_DATA} !== f1) begin
                n_err++; $display("FAIL rnd_fwd1_%0d: got %b/%h want %b/%h", i, FWD1_HIT, FWD1_DATA, f1[DW], f1[DW-1:0]); end
            n_cmp++; if ({FWD2_HIT, FWD2_DATA} !== f2) begin
                n_err++; $display("FAIL rnd_fwd2_%0d: got %b/%h want %b/%h", i, FWD2_HIT, FWD2_DATA, f2[DW], f2[DW-1:0]); end
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_fill();
        test_forward();
        test_addr_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
